operand_fetch: RTL and testbench
================================

# operand_fetch

Sequencer that fetches a 16-bit operand as two consecutive bytes from byte-wide memory and loads it into a downstream two-half 16-bit register. It drives that register's high-load strobe, low-load strobe and 8-bit data input. It owns the fetch pointer (program counter) and advances it by one per byte fetched. It sits between the memory interface and the operand/address registers of the CPU datapath.

## Interface
Parameters:
- HIGH_FIRST, 1, byte order. 1: first byte fetched goes to the high half. 0: first byte goes to the low half.

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  request a 2-byte fetch; sampled only in IDLE
- load_pc  in  1  load pc_in into fetch pointer; sampled only in IDLE
- pc_in  in  16  new fetch pointer value
- mem_ready  in  1  memory has valid data on mem_data this cycle
- mem_data  in  8  read data from memory
- mem_read  out  1  read request; high in FETCH1/FETCH2
- mem_addr  out  16  read address, equal to pc_out
- set_high  out  1  one-cycle strobe: load half_value into high byte of downstream register
- set_low  out  1  one-cycle strobe: load half_value into low byte
- half_value  out  8  byte to load; valid while either strobe is high
- pc_out  out  16  current fetch pointer
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: fetch complete

## Operation
- States:
  - IDLE → FETCH1 on start.
  - FETCH1 → FETCH2 on mem_ready.
  - FETCH2 → DONE on mem_ready.
  - DONE → IDLE unconditionally.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- IDLE:
  - load_pc=1: pc ← pc_in.
  - start=1: go to FETCH1.
  - Both high in the same cycle: pc ← pc_in and fetch proceeds from pc_in.
- FETCH1/FETCH2: mem_read=1, mem_addr=pc. Stays in the state indefinitely while mem_ready=0 (wait states).
- On the edge where mem_ready=1 in FETCH1:
  - half_value ← mem_data.
  - Strobe for the first byte asserts for exactly the next cycle: set_high if HIGH_FIRST=1, else set_low.
  - pc ← pc+1.
- On the edge where mem_ready=1 in FETCH2:
  - half_value ← mem_data.
  - The other strobe asserts for the next cycle.
  - pc ← pc+1.
- DONE: done=1 for one cycle, coincident with the second strobe.
- set_high and set_low are never high in the same cycle. Each is high exactly once per fetch.
- pc arithmetic is 16-bit modulo: 0xFFFF+1 = 0x0000, no carry or flag.
- Ignored inputs:
  - start and load_pc while busy=1.
  - mem_ready outside FETCH1/FETCH2.
  - mem_data when mem_ready=0.

## Timing
- Reset (reset=0 at an edge), values after that edge:
  - state=IDLE, pc_out=0, mem_addr=0, half_value=0.
  - mem_read=0, set_high=0, set_low=0, busy=0, done=0.
- Reset mid-fetch abandons the fetch:
  - No further strobes and no done.
  - The downstream register is also reset by the shared reset line.
- Zero-wait-state latency, with start sampled at edge E0:
  - Cycle after E0: FETCH1, mem_read=1.
  - Cycle after E1: FETCH2, first strobe.
  - Cycle after E2: DONE, second strobe, done=1.
  - Cycle after E3: IDLE; the downstream 16-bit value is valid in this cycle.
- Each wait cycle (mem_ready=0 in FETCH1/FETCH2) adds exactly one cycle.
- Back-to-back fetch: start may be asserted in the first IDLE cycle after DONE. Minimum fetch period is 4 cycles.
- pc_out advances on the same edges that launch the strobes. After done, pc_out = start pc + 2.

## Test plan
- Reset: drive reset=0 for 2 cycles mid-FETCH2 → all outputs 0, state IDLE, no strobe or done afterwards.
- Basic fetch, HIGH_FIRST=1:
  - Stimulus: load_pc with 0x1000, start, zero wait states, memory returns 0xAB then 0xCD.
  - Required: set_high with 0xAB, then set_low with 0xCD.
  - Required: done 3 cycles after start; downstream register reads 0xABCD; pc_out=0x1002.
- Wait states:
  - Stimulus: mem_ready low for 3 cycles in FETCH1 and 2 cycles in FETCH2.
  - Required: done 8 cycles after start; mem_addr holds 0x1000 then 0x1001 throughout the waits.
- Wrap-around: pc_in=0xFFFF → reads at addresses 0xFFFF then 0x0000; pc_out=0x0001 after done.
- Ignored and simultaneous inputs:
  - start and load_pc pulsed while busy → no effect on pc or sequence.
  - load_pc and start in the same IDLE cycle → first read at the new pc_in.
  - mem_ready pulsed in IDLE → no strobes.
- HIGH_FIRST=0, bytes 0x12 then 0x34 → set_low carries 0x12, set_high carries 0x34, register reads 0x3412.

Source files
------------

// File: rtl/operand_fetch.sv
// Two-byte operand fetch sequencer: reads consecutive bytes at the fetch pointer
// and strobes them into the high/low halves of a downstream 16-bit register.
module operand_fetch #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        load_pc,
    input  logic [15:0] pc_in,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic        mem_read,
    output logic [15:0] mem_addr,
    output logic        set_high,
    output logic        set_low,
    output logic [7:0]  half_value,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state
);

    // Memory handshake: mem_read is held high in FETCH1/FETCH2 with mem_addr
    // stable; a byte is accepted on any rising edge where mem_read and
    // mem_ready are both high, otherwise the cycle is a wait state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_q;
    logic [7:0]  half_q;
    logic        set_high_q;
    logic        set_low_q;
    logic        accept;
    logic        first_byte;

    assign accept     = ((state_q == FETCH1) || (state_q == FETCH2)) && mem_ready;
    assign first_byte = (state_q == FETCH1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = FETCH1;
            FETCH1:  if (mem_ready) state_d = FETCH2;
            FETCH2:  if (mem_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read = (state_q == FETCH1) || (state_q == FETCH2);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    // Datapath registers; strobes are registered so they appear the cycle after the byte is taken.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q       <= 16'h0000;
            half_q     <= 8'h00;
            set_high_q <= 1'b0;
            set_low_q  <= 1'b0;
        end else begin
            set_high_q <= accept && (first_byte == HIGH_FIRST);
            set_low_q  <= accept && (first_byte != HIGH_FIRST);
            if (accept) begin
                half_q <= mem_data;
                pc_q   <= pc_q + 16'h0001;
            end else if ((state_q == IDLE) && load_pc) begin
                pc_q <= pc_in;
            end
        end
    end

    assign mem_addr   = pc_q;
    assign pc_out     = pc_q;
    assign half_value = half_q;
    assign set_high   = set_high_q;
    assign set_low    = set_low_q;
    assign state      = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; runs a HIGH_FIRST=1 and a HIGH_FIRST=0 instance on shared inputs.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        load_pc;
    logic [15:0] pc_in;
    logic        mem_ready;
    logic [7:0]  mem_data;

    logic        h_mem_read, h_set_high, h_set_low, h_busy, h_done;
    logic [15:0] h_mem_addr, h_pc_out;
    logic [7:0]  h_half;
    logic [1:0]  h_state;
    logic        l_mem_read, l_set_high, l_set_low, l_busy, l_done;
    logic [15:0] l_mem_addr, l_pc_out;
    logic [7:0]  l_half;
    logic [1:0]  l_state;

    logic [15:0] h_reg;
    logic [15:0] l_reg;
    int          total = 0;
    int          bad = 0;
    int          cnt;
    bit          watch = 1'b0;

    always #5 clock = ~clock;

    operand_fetch #(.HIGH_FIRST(1'b1)) dut_hi (
        .clock(clock), .reset(reset), .start(start), .load_pc(load_pc), .pc_in(pc_in),
        .mem_ready(mem_ready), .mem_data(mem_data), .mem_read(h_mem_read), .mem_addr(h_mem_addr),
        .set_high(h_set_high), .set_low(h_set_low), .half_value(h_half), .pc_out(h_pc_out),
        .busy(h_busy), .done(h_done), .state(h_state)
    );

    operand_fetch #(.HIGH_FIRST(1'b0)) dut_lo (
        .clock(clock), .reset(reset), .start(start), .load_pc(load_pc), .pc_in(pc_in),
        .mem_ready(mem_ready), .mem_data(mem_data), .mem_read(l_mem_read), .mem_addr(l_mem_addr),
        .set_high(l_set_high), .set_low(l_set_low), .half_value(l_half), .pc_out(l_pc_out),
        .busy(l_busy), .done(l_done), .state(l_state)
    );

    // Downstream two-half registers, cleared by the shared reset line.
    always @(posedge clock) begin
        if (!reset) begin
            h_reg <= 16'h0000;
            l_reg <= 16'h0000;
        end else begin
            if (h_set_high) h_reg[15:8] <= h_half;
            if (h_set_low)  h_reg[7:0]  <= h_half;
            if (l_set_high) l_reg[15:8] <= l_half;
            if (l_set_low)  l_reg[7:0]  <= l_half;
        end
    end

    always @(negedge clock) begin
        if (watch) begin
            total++;
            if ((h_set_high && h_set_low) || (l_set_high && l_set_low)) begin
                bad++;
                $display("FAIL strobe_excl: hi=%b%b lo=%b%b, required never both high", h_set_high, h_set_low, l_set_high, l_set_low);
            end
        end
    end

    task automatic step;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs;
        start = 1'b0; load_pc = 1'b0; mem_ready = 1'b0;
        mem_data = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset;
        reset = 1'b0; pc_in = 16'h5555; idle_inputs();
        step(); step();
        total++; if (h_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d, required 0", h_state); end
        total++; if (h_pc_out !== 16'h0000 || h_mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_pc: pc=%h addr=%h, required 0000", h_pc_out, h_mem_addr); end
        total++; if (h_half !== 8'h00) begin bad++; $display("FAIL reset_half: got %h, required 00", h_half); end
        total++; if ({h_mem_read, h_set_high, h_set_low, h_busy, h_done} !== 5'b0) begin bad++; $display("FAIL reset_ctl: got %b, required 00000", {h_mem_read, h_set_high, h_set_low, h_busy, h_done}); end
        reset = 1'b1;
        watch = 1'b1;
    endtask

    task automatic test_basic;
        load_pc = 1'b1; pc_in = 16'h1000;
        step();
        total++; if (h_pc_out !== 16'h1000 || h_busy !== 1'b0) begin bad++; $display("FAIL basic_load: pc=%h busy=%b, required 1000/0", h_pc_out, h_busy); end
        load_pc = 1'b0; start = 1'b1;
        step();
        total++; if (h_state !== 2'd1 || h_mem_read !== 1'b1 || h_mem_addr !== 16'h1000) begin bad++; $display("FAIL basic_fetch1: state=%0d rd=%b addr=%h, required 1/1/1000", h_state, h_mem_read, h_mem_addr); end
        start = 1'b0; mem_ready = 1'b1; mem_data = 8'hAB;
        step();
        total++; if (h_set_high !== 1'b1 || h_set_low !== 1'b0 || h_half !== 8'hAB) begin bad++; $display("FAIL basic_first: sh=%b sl=%b half=%h, required 1/0/AB", h_set_high, h_set_low, h_half); end
        total++; if (h_pc_out !== 16'h1001 || h_mem_addr !== 16'h1001 || h_done !== 1'b0) begin bad++; $display("FAIL basic_pc1: pc=%h addr=%h done=%b, required 1001/1001/0", h_pc_out, h_mem_addr, h_done); end
        mem_data = 8'hCD;
        step();
        total++; if (h_set_low !== 1'b1 || h_set_high !== 1'b0 || h_half !== 8'hCD || h_done !== 1'b1) begin bad++; $display("FAIL basic_second: sh=%b sl=%b half=%h done=%b, required 0/1/CD/1", h_set_high, h_set_low, h_half, h_done); end
        total++; if (h_pc_out !== 16'h1002 || h_mem_read !== 1'b0) begin bad++; $display("FAIL basic_pc2: pc=%h rd=%b, required 1002/0", h_pc_out, h_mem_read); end
        idle_inputs();
        step();
        total++; if (h_reg !== 16'hABCD || h_busy !== 1'b0 || h_done !== 1'b0) begin bad++; $display("FAIL basic_result: reg=%h busy=%b done=%b, required ABCD/0/0", h_reg, h_busy, h_done); end
    endtask

    task automatic test_wait_states;
        load_pc = 1'b1; pc_in = 16'h1000;
        step();
        load_pc = 1'b0; start = 1'b1;
        step();
        cnt = 1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0; mem_data = 8'($urandom_range(0, 255));
            step(); cnt++;
            total++; if (h_state !== 2'd1 || h_mem_addr !== 16'h1000 || h_mem_read !== 1'b1 || h_set_high !== 1'b0) begin bad++; $display("FAIL wait1_%0d: state=%0d addr=%h rd=%b sh=%b, required 1/1000/1/0", i, h_state, h_mem_addr, h_mem_read, h_set_high); end
        end
        mem_ready = 1'b1; mem_data = 8'h5A;
        step(); cnt++;
        total++; if (h_set_high !== 1'b1 || h_half !== 8'h5A) begin bad++; $display("FAIL wait_first: sh=%b half=%h, required 1/5A", h_set_high, h_half); end
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b0; mem_data = 8'($urandom_range(0, 255));
            step(); cnt++;
            total++; if (h_state !== 2'd2 || h_mem_addr !== 16'h1001 || h_set_high !== 1'b0 || h_set_low !== 1'b0 || h_half !== 8'h5A) begin bad++; $display("FAIL wait2_%0d: state=%0d addr=%h sh=%b sl=%b half=%h, required 2/1001/0/0/5A", i, h_state, h_mem_addr, h_set_high, h_set_low, h_half); end
        end
        mem_ready = 1'b1; mem_data = 8'hC3;
        step(); cnt++;
        total++; if (h_done !== 1'b1 || cnt !== 8 || h_set_low !== 1'b1) begin bad++; $display("FAIL wait_done: done=%b cycles=%0d sl=%b, required 1/8/1", h_done, cnt, h_set_low); end
        idle_inputs();
        step();
        total++; if (h_reg !== 16'h5AC3 || h_pc_out !== 16'h1002) begin bad++; $display("FAIL wait_result: reg=%h pc=%h, required 5AC3/1002", h_reg, h_pc_out); end
    endtask

    task automatic test_wrap;
        load_pc = 1'b1; pc_in = 16'hFFFF;
        step();
        load_pc = 1'b0; start = 1'b1;
        step();
        total++; if (h_mem_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr1: got %h, required FFFF", h_mem_addr); end
        start = 1'b0; mem_ready = 1'b1; mem_data = 8'h11;
        step();
        total++; if (h_mem_addr !== 16'h0000 || h_pc_out !== 16'h0000) begin bad++; $display("FAIL wrap_addr2: addr=%h pc=%h, required 0000", h_mem_addr, h_pc_out); end
        mem_data = 8'h22;
        step();
        total++; if (h_pc_out !== 16'h0001 || h_done !== 1'b1) begin bad++; $display("FAIL wrap_pc: pc=%h done=%b, required 0001/1", h_pc_out, h_done); end
        idle_inputs();
        step();
        total++; if (h_reg !== 16'h1122) begin bad++; $display("FAIL wrap_result: got %h, required 1122", h_reg); end
    endtask

    task automatic test_ignored;
        start = 1'b1;
        step();
        start = 1'b1; load_pc = 1'b1; pc_in = 16'h7777; mem_ready = 1'b0;
        step();
        total++; if (h_state !== 2'd1 || h_pc_out !== 16'h0001) begin bad++; $display("FAIL ign_fetch1: state=%0d pc=%h, required 1/0001", h_state, h_pc_out); end
        mem_ready = 1'b1; mem_data = 8'h9E;
        step();
        mem_data = 8'h4F;
        step();
        total++; if (h_done !== 1'b1 || h_pc_out !== 16'h0003) begin bad++; $display("FAIL ign_done: done=%b pc=%h, required 1/0003", h_done, h_pc_out); end
        step();
        total++; if (h_state !== 2'd0 || h_pc_out !== 16'h0003 || h_reg !== 16'h9E4F) begin bad++; $display("FAIL ign_idle: state=%0d pc=%h reg=%h, required 0/0003/9E4F", h_state, h_pc_out, h_reg); end
        start = 1'b0; load_pc = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (h_set_high !== 1'b0 || h_set_low !== 1'b0 || h_state !== 2'd0 || h_pc_out !== 16'h0003) begin bad++; $display("FAIL ign_ready_%0d: sh=%b sl=%b state=%0d pc=%h, required 0/0/0/0003", i, h_set_high, h_set_low, h_state, h_pc_out); end
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous;
        load_pc = 1'b1; start = 1'b1; pc_in = 16'h2040;
        step();
        total++; if (h_state !== 2'd1 || h_mem_addr !== 16'h2040) begin bad++; $display("FAIL simul_addr: state=%0d addr=%h, required 1/2040", h_state, h_mem_addr); end
        load_pc = 1'b0; start = 1'b0; mem_ready = 1'b1; mem_data = 8'h01;
        step();
        mem_data = 8'h02;
        step();
        idle_inputs();
        step();
        total++; if (h_reg !== 16'h0102 || h_pc_out !== 16'h2042) begin bad++; $display("FAIL simul_result: reg=%h pc=%h, required 0102/2042", h_reg, h_pc_out); end
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        step();
        start = 1'b0; mem_ready = 1'b1; mem_data = 8'hA1;
        step();
        mem_data = 8'hB2;
        step();
        idle_inputs();
        step();
        start = 1'b1;
        step();
        total++; if (h_state !== 2'd1 || h_mem_addr !== 16'h2044 || h_reg !== 16'hA1B2) begin bad++; $display("FAIL b2b_restart: state=%0d addr=%h reg=%h, required 1/2044/A1B2", h_state, h_mem_addr, h_reg); end
        start = 1'b0; mem_ready = 1'b1; mem_data = 8'hC3;
        step();
        mem_data = 8'hD4;
        step();
        total++; if (h_done !== 1'b1 || h_pc_out !== 16'h2046) begin bad++; $display("FAIL b2b_done: done=%b pc=%h, required 1/2046", h_done, h_pc_out); end
        idle_inputs();
        step();
        total++; if (h_reg !== 16'hC3D4) begin bad++; $display("FAIL b2b_result: got %h, required C3D4", h_reg); end
    endtask

    task automatic test_high_first_zero;
        load_pc = 1'b1; start = 1'b1; pc_in = 16'h0300;
        step();
        load_pc = 1'b0; start = 1'b0; mem_ready = 1'b1; mem_data = 8'h12;
        step();
        total++; if (l_set_low !== 1'b1 || l_set_high !== 1'b0 || l_half !== 8'h12) begin bad++; $display("FAIL lo_first: sh=%b sl=%b half=%h, required 0/1/12", l_set_high, l_set_low, l_half); end
        mem_data = 8'h34;
        step();
        total++; if (l_set_high !== 1'b1 || l_set_low !== 1'b0 || l_half !== 8'h34 || l_done !== 1'b1) begin bad++; $display("FAIL lo_second: sh=%b sl=%b half=%h done=%b, required 1/0/34/1", l_set_high, l_set_low, l_half, l_done); end
        idle_inputs();
        step();
        total++; if (l_reg !== 16'h3412 || h_reg !== 16'h1234 || l_pc_out !== 16'h0302) begin bad++; $display("FAIL lo_result: lo=%h hi=%h pc=%h, required 3412/1234/0302", l_reg, h_reg, l_pc_out); end
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        step();
        start = 1'b0; mem_ready = 1'b1; mem_data = 8'h99;
        step();
        total++; if (h_state !== 2'd2 || h_set_high !== 1'b1) begin bad++; $display("FAIL rst_setup: state=%0d sh=%b, required 2/1", h_state, h_set_high); end
        reset = 1'b0; mem_data = 8'h77;
        step();
        total++; if ({h_mem_read, h_set_high, h_set_low, h_busy, h_done} !== 5'b0 || h_state !== 2'd0 || h_pc_out !== 16'h0000 || h_half !== 8'h00 || h_reg !== 16'h0000) begin bad++; $display("FAIL rst_mid: ctl=%b state=%0d pc=%h half=%h reg=%h, required all zero", {h_mem_read, h_set_high, h_set_low, h_busy, h_done}, h_state, h_pc_out, h_half, h_reg); end
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({h_set_high, h_set_low, h_done, h_busy, l_set_high, l_set_low, l_done} !== 7'b0) begin bad++; $display("FAIL rst_after_%0d: got %b, required 0000000", i, {h_set_high, h_set_low, h_done, h_busy, l_set_high, l_set_low, l_done}); end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        pc_in = 16'h0000;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_basic();
        test_wait_states();
        test_wrap();
        test_ignored();
        test_simultaneous();
        test_back_to_back();
        test_high_first_zero();
        test_reset_mid();
        watch = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
